mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the simpleCPU datapath. It accepts two register operands and an operation code, computes over a fixed number of cycles, and holds the 64-bit result in HI/LO registers. HI and LO feed the write-back data-select multiplexer directly. The unit signals completion with a one-cycle DONE pulse and ignores new requests while busy.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu_neg32.sv | 24 ++
 rtl/mul_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// +--------------------------------------------------------------+
// | mdu_pkg : opcodes, FSM states and iteration count for the MDU |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

  localparam int ITER = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_neg32.sv
// +--------------------------------------------------------------+
// | mdu_neg32 : conditional two's-complement negate, carry-chain  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module mdu_neg32 (
  input  logic [31:0] din,
  input  logic        neg,
  input  logic        cin,
  output logic [31:0] dout,
  output logic        cout
);

  logic [32:0] w_sum;

  // cin=1 for a standalone negate; chain the lower word's cout for wider words
  assign w_sum = {1'b0, ~din} + {32'b0, cin};
  assign dout  = neg ? w_sum[31:0] : din;
  assign cout  = neg & w_sum[32];

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// +--------------------------------------------------------------+
// | mul_div_unit : iterative 32-bit multiply/divide into HI/LO    |
// | Option macro MDU_FAST_MUL_EN: single-cycle multiply path      |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_ma;
  logic [31:0] r_mb;
  logic        r_sa;
  logic        r_sb;
  logic [63:0] r_acc;
  logic [32:0] r_rem;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed_in;
  logic        w_sa_in;
  logic        w_sb_in;
  logic [31:0] w_ma;
  logic [31:0] w_mb;
  logic        w_ca_unused;
  logic        w_cb_unused;
  logic        w_is_div;
  logic [32:0] w_mul_sum;
  logic [32:0] w_rsh;
  logic [33:0] w_diff;
  logic        w_ge;
  logic [31:0] w_lo_fix;
  logic [31:0] w_hi_fix;
  logic        w_lo_cout;
  logic        w_hi_cout_unused;

  assign w_signed_in = (op == OP_MULT) || (op == OP_DIV);
  assign w_sa_in     = w_signed_in & a[31];
  assign w_sb_in     = w_signed_in & b[31];

  mdu_neg32 u_neg_a (.din(a), .neg(w_sa_in), .cin(1'b1), .dout(w_ma), .cout(w_ca_unused));
  mdu_neg32 u_neg_b (.din(b), .neg(w_sb_in), .cin(1'b1), .dout(w_mb), .cout(w_cb_unused));

  assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_DIV);

  // Multiply: multiplier sits in acc[31:0] and shifts out as the product shifts in
  assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_ma} : 33'd0);

  // Divide: dividend/quotient share acc[31:0]; restoring step on a 33-bit remainder
  assign w_rsh  = {r_rem[31:0], r_acc[31]};
  assign w_diff = {1'b0, w_rsh} - {2'b0, r_mb};
  assign w_ge   = ~w_diff[33];

  // Low word holds product-low or quotient; high word product-high or remainder
  mdu_neg32 u_fix_lo (
    .din (r_acc[31:0]),
    .neg (r_sa ^ r_sb),
    .cin (1'b1),
    .dout(w_lo_fix),
    .cout(w_lo_cout)
  );

  mdu_neg32 u_fix_hi (
    .din (w_is_div ? r_rem[31:0] : r_acc[63:32]),
    .neg (w_is_div ? r_sa : (r_sa ^ r_sb)),
    .cin (w_is_div ? 1'b1 : w_lo_cout),
    .dout(w_hi_fix),
    .cout(w_hi_cout_unused)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 2'b00;
      r_a     <= 32'd0;
      r_ma    <= 32'd0;
      r_mb    <= 32'd0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_acc   <= 64'd0;
      r_rem   <= 33'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_a    <= a;
            r_ma   <= w_ma;
            r_mb   <= w_mb;
            r_sa   <= w_sa_in;
            r_sb   <= w_sb_in;
            r_rem  <= 33'd0;
            r_cnt  <= 5'd0;
            r_busy <= 1'b1;
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) begin
              r_acc   <= {32'd0, w_ma} * {32'd0, w_mb};
              r_state <= S_FIX;
            end else begin
              r_acc   <= {32'd0, w_ma};
              r_state <= S_CALC;
            end
`else
            r_acc   <= op[1] ? {32'd0, w_ma} : {32'd0, w_mb};
            r_state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          if (w_is_div) begin
            r_rem        <= w_ge ? w_diff[32:0] : w_rsh;
            r_acc[31:0]  <= {r_acc[30:0], w_ge};
          end else begin
            r_acc <= {w_mul_sum, r_acc[31:1]};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(ITER - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_is_div && (r_mb == 32'd0)) begin
            r_hi <= r_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_hi_fix;
            r_lo <= w_lo_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +--------------------------------------------------------------+
// | tb_mul_div_unit : directed self-checking bench for the MDU    |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
`default_nettype none

module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .clrn (clrn),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Returns 1ns after the START edge with operands scrambled
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    forever begin
      if (done) break;
      if (busy) bc++;
      if (cyc >= 100) break;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    int cyc, bc;
    issue(o, x, y);
    wait_done(cyc, bc);
    check({tag, " latency"}, 64'(cyc), 64'(lat_of(o)));
    check({tag, " busy cycles"}, 64'(bc), 64'(lat_of(o)));
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(ehi));
    check({tag, " lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    int cyc, bc, dcount;
    clrn  = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    clrn = 1'b1;

    run("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("done one cycle", 64'(done), 64'd0);
    check("hi held", 64'(hi), 64'hFFFF_FFFE);

    run("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run("divu by zero", OP_DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    run("div -5 by zero", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Second START at t0+10 must be ignored
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd50;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bc);
    check("ignored start latency", 64'(cyc), 64'd23);
    check("ignored start hi", 64'(hi), 64'd2);
    check("ignored start lo", 64'(lo), 64'd14);

    // New START in the DONE cycle is accepted
    start = 1'b1;
    op    = OP_MULTU;
    a     = 32'd6;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    check("b2b done low", 64'(done), 64'd0);
    check("b2b accepted busy", 64'(busy), 64'd1);
    wait_done(cyc, bc);
    check("b2b latency", 64'(cyc), 64'(lat_of(OP_MULTU)));
    check("b2b hi", 64'(hi), 64'd0);
    check("b2b lo", 64'(lo), 64'd42);

    // Asynchronous abort mid-divide
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    clrn   = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("no done after abort", 64'(dcount), 64'd0);
    check("idle after abort", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
